// File: rtl/draw_reticle.sv
// Crosshair overlay on a VGA pixel stream with a frame-counted hit-flash sequence.
// Every output is registered once; the timing fields are the inputs delayed by one clock.
module draw_reticle #(
    parameter int          ARM_LEN        = 20,
    parameter int          HALF_THICK     = 0,
    parameter int          GAP            = 0,
    parameter logic [11:0] COLOUR         = 12'hf_0_0,
    parameter logic [11:0] FLASH_COLOUR   = 12'hf_f_f,
    parameter int          FLASH_FRAMES   = 6,
    parameter int          HOLDOFF_FRAMES = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic        draw_en,
    input  logic        trigger,
    output logic        hit_accept,
    input  logic [11:0] in_hcount,
    input  logic        in_hsync,
    input  logic        in_hblnk,
    input  logic [11:0] in_vcount,
    input  logic        in_vsync,
    input  logic        in_vblnk,
    input  logic [11:0] in_rgb,
    output logic [11:0] out_hcount,
    output logic        out_hsync,
    output logic        out_hblnk,
    output logic [11:0] out_vcount,
    output logic        out_vsync,
    output logic        out_vblnk,
    output logic [11:0] out_rgb
);

    localparam logic [13:0] ARM_W   = 14'(ARM_LEN);
    localparam logic [13:0] THICK_W = 14'(HALF_THICK);
    localparam logic [13:0] GAP_W   = 14'(GAP);
    localparam logic [8:0]  FLASH_N = 9'(FLASH_FRAMES);
    localparam logic [8:0]  HOLD_N  = 9'(HOLDOFF_FRAMES);

    typedef enum logic [1:0] {IDLE, FLASH, HOLDOFF} state_t;

    state_t      state;
    logic [7:0]  fcnt;
    logic [8:0]  fcnt_inc;
    logic        vblnk_prev;
    logic        frame_start;
    logic [11:0] x_reg, y_reg;
    logic [11:0] x_lat, y_lat;

    logic signed [13:0] dx, dy;
    logic [13:0] adx, ady;
    logic        h_arm, v_arm, drawn;
    logic [11:0] reticle_colour;

    assign frame_start = in_vblnk & ~vblnk_prev;
    assign fcnt_inc    = {1'b0, fcnt} + 9'd1;

    // 14-bit signed differences keep arms clipped at the screen edges instead of wrapping.
    always_comb begin
        dx = $signed({2'b00, in_hcount}) - $signed({2'b00, x_lat});
        dy = $signed({2'b00, in_vcount}) - $signed({2'b00, y_lat});
        adx = dx[13] ? -dx : dx;
        ady = dy[13] ? -dy : dy;
        h_arm = (ady <= THICK_W) && (adx >= GAP_W) && (adx <= ARM_W);
        v_arm = (adx <= THICK_W) && (ady >= GAP_W) && (ady <= ARM_W);
        drawn = draw_en && !in_hblnk && !in_vblnk && (h_arm || v_arm);
        reticle_colour = (state == FLASH && !fcnt[0]) ? FLASH_COLOUR : COLOUR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_hcount <= '0;
            out_hsync  <= 1'b0;
            out_hblnk  <= 1'b0;
            out_vcount <= '0;
            out_vsync  <= 1'b0;
            out_vblnk  <= 1'b0;
            out_rgb    <= '0;
            vblnk_prev <= 1'b0;
            x_reg      <= '0;
            y_reg      <= '0;
            x_lat      <= '0;
            y_lat      <= '0;
        end else begin
            out_hcount <= in_hcount;
            out_hsync  <= in_hsync;
            out_hblnk  <= in_hblnk;
            out_vcount <= in_vcount;
            out_vsync  <= in_vsync;
            out_vblnk  <= in_vblnk;
            out_rgb    <= drawn ? reticle_colour : in_rgb;
            vblnk_prev <= in_vblnk;
            x_reg      <= xpos;
            y_reg      <= ypos;
            // Position only moves at frame start so a frame is never torn.
            if (frame_start) begin
                x_lat <= x_reg;
                y_lat <= y_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            fcnt       <= '0;
            hit_accept <= 1'b0;
        end else begin
            hit_accept <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger && draw_en) begin
                        state      <= FLASH;
                        fcnt       <= '0;
                        hit_accept <= 1'b1;
                    end
                end
                FLASH: begin
                    if (frame_start) begin
                        if (fcnt_inc == FLASH_N) begin
                            fcnt  <= '0;
                            state <= (HOLDOFF_FRAMES == 0) ? IDLE : HOLDOFF;
                        end else begin
                            fcnt <= fcnt_inc[7:0];
                        end
                    end
                end
                HOLDOFF: begin
                    if (frame_start) begin
                        if (fcnt_inc == HOLD_N) begin
                            fcnt  <= '0;
                            state <= IDLE;
                        end else begin
                            fcnt <= fcnt_inc[7:0];
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    fcnt  <= '0;
                end
            endcase
        end
    end

endmodule
